// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Purpose  : IF/ID pipeline register for the pipelined MIPS datapath.
//            Latches the fetched instruction and its PC, then decodes the
//            control-transfer instructions (beq, j, jal, jr). The resulting
//            branch/jump controls go straight back to the fetch unit.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            instr_F, pc_F              - fetched instruction and its PC
//            stall, flush               - hazard-unit controls
//            rs_data, rt_data           - forwarded GRF read data for decode
//            instr_D, pc_D, valid_D     - registered stage contents
//            rs_addr, rt_addr           - GRF read addresses from instr_D
//            ifB, ifJal, link, ifJr     - gated control-transfer decodes
//            dataJal, datars            - raw jump target fields
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_F,
    input  logic [31:0] pc_F,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        ifB,
    output logic        ifJal,
    output logic        link,
    output logic [25:0] dataJal,
    output logic        ifJr,
    output logic [31:0] datars
);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_FN_JR      = 6'b001000;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    // Stage register. Stall outranks flush so a stalled instruction is
    // never lost to a simultaneous restart request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_instr <= r_instr;
            r_pc    <= r_pc;
            r_valid <= r_valid;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= pc_F;
            r_valid <= 1'b0;
        end else begin
            r_instr <= instr_F;
            r_pc    <= pc_F;
            r_valid <= 1'b1;
        end
    end

    // Decode from the registered instruction only; nothing from the fetch
    // side reaches an output combinationally.
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_is_beq;
    logic       w_is_j;
    logic       w_is_jal;
    logic       w_is_jr;
    logic       w_gate;
    logic       w_equal;

    assign w_op     = r_instr[31:26];
    assign w_funct  = r_instr[5:0];
    assign w_is_beq = (w_op == c_OP_BEQ);
    assign w_is_j   = (w_op == c_OP_J);
    assign w_is_jal = (w_op == c_OP_JAL);
    assign w_is_jr  = (w_op == c_OP_SPECIAL) && (w_funct == c_FN_JR);

    // While stalled the forwarded operands may still be stale, so every
    // control is suppressed; bubbles never redirect fetch either.
    assign w_gate   = r_valid & ~stall;
    assign w_equal  = (rs_data == rt_data);

    assign ifB      = w_gate & w_is_beq & w_equal;
    assign ifJal    = w_gate & (w_is_j | w_is_jal);
    assign link     = w_gate & w_is_jal;
    assign ifJr     = w_gate & w_is_jr;

    // Raw fields; target arithmetic is done in the fetch unit.
    assign instr_D  = r_instr;
    assign pc_D     = r_pc;
    assign valid_D  = r_valid;
    assign rs_addr  = r_instr[25:21];
    assign rt_addr  = r_instr[20:16];
    assign dataJal  = r_instr[25:0];
    assign datars   = rs_data;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Self-checking bench for if_id_stage. A behavioural model of the
//            stage contents is compared against the DUT every cycle, and a
//            directed sequence pins literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic        stall;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        ifB;
    logic        ifJal;
    logic        link;
    logic [25:0] dataJal;
    logic        ifJr;
    logic [31:0] datars;

    int tests = 0;
    int fails = 0;

    if_id_stage dut (
        .clk     (clk),
        .reset   (reset),
        .instr_F (instr_F),
        .pc_F    (pc_F),
        .stall   (stall),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .instr_D (instr_D),
        .pc_D    (pc_D),
        .valid_D (valid_D),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .ifB     (ifB),
        .ifJal   (ifJal),
        .link    (link),
        .dataJal (dataJal),
        .ifJr    (ifJr),
        .datars  (datars)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_instr <= 32'h0;
            m_pc    <= 32'h3000;
            m_valid <= 1'b0;
            m_ok    <= 1'b1;
        end else if (!stall) begin
            m_instr <= flush ? 32'h0 : instr_F;
            m_pc    <= pc_F;
            m_valid <= !flush;
        end
    end

    // Every-cycle compare at the falling edge, away from the register update.
    always @(negedge clk) begin
        if (m_ok) begin
            logic e_b, e_jal, e_link, e_jr;
            e_b = 0; e_jal = 0; e_link = 0; e_jr = 0;
            if (m_valid && !stall) begin
                case (m_instr[31:26])
                    6'd4: e_b    = (rs_data == rt_data);
                    6'd2: e_jal  = 1;
                    6'd3: begin e_jal = 1; e_link = 1; end
                    6'd0: e_jr   = (m_instr[5:0] == 6'd8);
                    default: ;
                endcase
            end
            chk("m_instr_D", instr_D, m_instr);
            chk("m_pc_D", pc_D, m_pc);
            chk("m_valid_D", {31'b0, valid_D}, {31'b0, m_valid});
            chk("m_ctrl", {28'b0, ifB, ifJal, link, ifJr}, {28'b0, e_b, e_jal, e_link, e_jr});
            chk("m_fields", {1'b0, rs_addr, dataJal}, {1'b0, m_instr[25:21], m_instr[25:0]});
            chk("m_rt_addr", {27'b0, rt_addr}, {27'b0, m_instr[20:16]});
            chk("m_datars", datars, rs_data);
            chk("m_onehot", {31'b0, (ifB + ifJal + ifJr) <= 1}, 32'h1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[31:26] = 6'd4;
            1: r[31:26] = 6'd2;
            2: r[31:26] = 6'd3;
            3: begin r[31:26] = 6'd0; r[5:0] = 6'd8; end
            4: r[31:26] = 6'd0;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; stall = 0; flush = 0;
        instr_F = 32'h0; pc_F = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        step();
        reset = 0;
        #1;
        chk("rst_pc", pc_D, 32'h3000);
        chk("rst_instr", instr_D, 32'h0);
        chk("rst_valid", {31'b0, valid_D}, 32'h0);
        chk("rst_ctrl", {28'b0, ifB, ifJal, link, ifJr}, 32'h0);
        chk("rst_fields", {1'b0, rs_addr, dataJal}, 32'h0);

        // beq $8,$9
        instr_F = 32'h1109_0003; pc_F = 32'h3004;
        step();
        rs_data = 5; rt_data = 5; #1;
        chk("beq_instr", instr_D, 32'h1109_0003);
        chk("beq_pc", pc_D, 32'h3004);
        chk("beq_valid", {31'b0, valid_D}, 32'h1);
        chk("beq_taken", {31'b0, ifB}, 32'h1);
        rt_data = 6; #1;
        chk("beq_not_taken", {31'b0, ifB}, 32'h0);

        // jal, then j
        instr_F = 32'h0C00_0C10; pc_F = 32'h3008;
        step();
        chk("jal_ctrl", {30'b0, ifJal, link}, 32'h3);
        chk("jal_target", {6'b0, dataJal}, 32'h0000_0C10);
        instr_F = 32'h0800_0C10; pc_F = 32'h300C;
        step();
        chk("j_ctrl", {30'b0, ifJal, link}, 32'h2);

        // jr $31
        instr_F = 32'h03E0_0008; pc_F = 32'h3010;
        step();
        rs_data = 32'h3010; #1;
        chk("jr_ctrl", {31'b0, ifJr}, 32'h1);
        chk("jr_datars", datars, 32'h3010);
        chk("jr_rs_addr", {27'b0, rs_addr}, 32'd31);

        // beq held by a 2-cycle stall
        instr_F = 32'h1109_0003; pc_F = 32'h3014;
        step();
        rs_data = 7; rt_data = 7; stall = 1; instr_F = 32'hDEAD_BEEF; pc_F = 32'h4000; #1;
        chk("stall_ifB0", {31'b0, ifB}, 32'h0);
        step();
        instr_F = 32'h0C00_0001;
        chk("stall_hold1", instr_D, 32'h1109_0003);
        chk("stall_ifB1", {31'b0, ifB}, 32'h0);
        step();
        chk("stall_hold2", pc_D, 32'h3014);
        stall = 0; #1;
        chk("stall_release", {31'b0, ifB}, 32'h1);
        instr_F = 32'h0109_5020; pc_F = 32'h3018;
        step();
        chk("add_no_ctrl", {28'b0, ifB, ifJal, link, ifJr}, 32'h0);

        // stall + flush: hold; flush alone: bubble
        stall = 1; flush = 1; instr_F = 32'h0C00_0002; pc_F = 32'h5000;
        step();
        chk("stflush_hold", instr_D, 32'h0109_5020);
        chk("stflush_valid", {31'b0, valid_D}, 32'h1);
        stall = 0; pc_F = 32'h3020;
        step();
        flush = 0;
        chk("flush_instr", instr_D, 32'h0);
        chk("flush_valid", {31'b0, valid_D}, 32'h0);
        chk("flush_pc", pc_D, 32'h3020);
        chk("flush_ctrl", {28'b0, ifB, ifJal, link, ifJr}, 32'h0);

        // reset mid-run with jal in decode
        instr_F = 32'h0C00_0C10; pc_F = 32'h3024;
        step();
        chk("pre_rst_jal", {31'b0, ifJal}, 32'h1);
        reset = 1;
        step();
        reset = 0; instr_F = 32'h0800_0040; pc_F = 32'h3100; #1;
        chk("midrst_pc", pc_D, 32'h3000);
        chk("midrst_instr", instr_D, 32'h0);
        chk("midrst_ifJal", {31'b0, ifJal}, 32'h0);
        step();
        chk("resume_instr", instr_D, 32'h0800_0040);
        chk("resume_valid", {31'b0, valid_D}, 32'h1);

        // randomized run, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            instr_F = rand_instr();
            pc_F    = $urandom;
            rs_data = $urandom_range(0, 3);
            rt_data = ($urandom_range(0, 1) == 0) ? rs_data : $urandom;
            step();
        end
        reset = 0; stall = 0; flush = 0;
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
